// File: rtl/cmd_cfg_pkg.sv
// cmd_cfg_pkg: shared definitions for the command/configuration block.
// Holds the command opcode encoding, the positive-acknowledge response byte
// and the controller state type.
package cmd_cfg_pkg;

    typedef enum logic [7:0] {
        OP_SET_PTCH  = 8'h02,
        OP_SET_ROLL  = 8'h03,
        OP_SET_YAW   = 8'h04,
        OP_SET_THRST = 8'h05,
        OP_CALIBRATE = 8'h06,
        OP_EMER_LAND = 8'h07,
        OP_MTRS_OFF  = 8'h08
    } opcode_t;

    localparam logic [7:0] POS_ACK = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SPIN    = 3'd1,
        ST_CAL     = 3'd2,
        ST_ACK     = 3'd3,
        ST_WAIT_TX = 3'd4
    } state_t;

endpackage

// File: rtl/cmd_cfg_spinup_tmr.sv
// spinup_tmr: free-running up counter that times motor spin-up before
// inertial calibration starts.
// Ports:
//   clk  - rising-edge clock
//   clr  - synchronous clear (highest priority)
//   en   - count enable
//   full - high while the counter holds all ones
module spinup_tmr #(
    parameter int unsigned WIDTH = 9
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic full
);

    logic [WIDTH-1:0] r_cnt;

    // Count register; clear doubles as the block reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign full = &r_cnt;

endmodule

// File: rtl/cmd_cfg.sv
// cmd_cfg: decodes 24-bit commands (opcode + 16-bit parameter) from the UART
// receiver, holds the flight setpoints, sequences motor spin-up and inertial
// calibration, and acknowledges each accepted command with one response byte.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   cmd_rdy/cmd/data    - command from the receiver
//   clr_cmd_rdy         - consumes the current command (combinational)
//   resp/send_resp      - response byte and its transmit request
//   resp_sent           - response transmission complete
//   d_ptch/d_roll/d_yaw - signed attitude setpoints
//   thrst               - unsigned thrust setpoint
//   strt_cal/cal_done   - calibration handshake
//   inertial_cal        - high during spin-up and calibration
//   motors_off          - forces motors off
module cmd_cfg
    import cmd_cfg_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_rdy,
    input  logic [7:0]         cmd,
    input  logic [15:0]        data,
    output logic               clr_cmd_rdy,
    output logic [7:0]         resp,
    output logic               send_resp,
    input  logic               resp_sent,
    output logic signed [15:0] d_ptch,
    output logic signed [15:0] d_roll,
    output logic signed [15:0] d_yaw,
    output logic [8:0]         thrst,
    output logic               strt_cal,
    output logic               inertial_cal,
    input  logic               cal_done,
    output logic               motors_off
);

    localparam int unsigned TMR_W = FAST_SIM ? 9 : 26;

    state_t             r_state;
    logic signed [15:0] r_d_ptch;
    logic signed [15:0] r_d_roll;
    logic signed [15:0] r_d_yaw;
    logic [8:0]         r_thrst;
    logic               r_motors_off;

    logic w_take;
    logic w_tmr_clr;
    logic w_tmr_en;
    logic w_full;

    // A command is consumed only in IDLE; everything is masked while in reset.
    assign w_take       = (r_state == ST_IDLE) && cmd_rdy && !rst;
    assign clr_cmd_rdy  = w_take;
    assign send_resp    = (r_state == ST_ACK) && !rst;
    assign strt_cal     = (r_state == ST_SPIN) && w_full && !rst;
    assign inertial_cal = ((r_state == ST_SPIN) || (r_state == ST_CAL)) && !rst;
    assign resp         = POS_ACK;

    assign w_tmr_clr = rst || (w_take && (cmd == OP_CALIBRATE));
    // Stop at all-ones so the terminal value holds for the single SPIN exit cycle.
    assign w_tmr_en  = (r_state == ST_SPIN) && !w_full;

    spinup_tmr #(
        .WIDTH (TMR_W)
    ) u_spinup_tmr (
        .clk  (clk),
        .clr  (w_tmr_clr),
        .en   (w_tmr_en),
        .full (w_full)
    );

    // Controller state and setpoint registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_d_ptch     <= '0;
            r_d_roll     <= '0;
            r_d_yaw      <= '0;
            r_thrst      <= '0;
            r_motors_off <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_rdy) begin
                        case (cmd)
                            OP_SET_PTCH: begin
                                r_d_ptch <= data;
                                r_state  <= ST_ACK;
                            end
                            OP_SET_ROLL: begin
                                r_d_roll <= data;
                                r_state  <= ST_ACK;
                            end
                            OP_SET_YAW: begin
                                r_d_yaw <= data;
                                r_state <= ST_ACK;
                            end
                            OP_SET_THRST: begin
                                r_thrst <= data[8:0];
                                r_state <= ST_ACK;
                            end
                            OP_CALIBRATE: begin
                                r_motors_off <= 1'b0;
                                r_state      <= ST_SPIN;
                            end
                            OP_EMER_LAND: begin
                                r_d_ptch <= '0;
                                r_d_roll <= '0;
                                r_d_yaw  <= '0;
                                r_thrst  <= '0;
                                r_state  <= ST_ACK;
                            end
                            OP_MTRS_OFF: begin
                                r_motors_off <= 1'b1;
                                r_state      <= ST_ACK;
                            end
                            // Unknown opcode: consumed silently, stay in IDLE.
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
                ST_SPIN: begin
                    if (w_full) begin
                        r_state <= ST_CAL;
                    end
                end
                ST_CAL: begin
                    if (cal_done) begin
                        r_state <= ST_ACK;
                    end
                end
                // resp_sent is only credited from WAIT_TX onward.
                ST_ACK: r_state <= ST_WAIT_TX;
                ST_WAIT_TX: begin
                    if (resp_sent) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign d_ptch     = r_d_ptch;
    assign d_roll     = r_d_roll;
    assign d_yaw      = r_d_yaw;
    assign thrst      = r_thrst;
    assign motors_off = r_motors_off;

endmodule

// File: tb/tb_cmd_cfg.sv
// tb_cmd_cfg: directed self-checking bench for cmd_cfg (FAST_SIM build).
module tb_cmd_cfg;

    logic        clk;
    logic        rst;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic [15:0] d_ptch;
    logic [15:0] d_roll;
    logic [15:0] d_yaw;
    logic [8:0]  thrst;
    logic        strt_cal;
    logic        inertial_cal;
    logic        cal_done;
    logic        motors_off;

    int n_vec;
    int n_err;
    int n_ack;
    int n_clr;
    int n_strt;

    cmd_cfg #(
        .FAST_SIM (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_rdy      (cmd_rdy),
        .cmd          (cmd),
        .data         (data),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .resp         (resp),
        .send_resp    (send_resp),
        .resp_sent    (resp_sent),
        .d_ptch       (d_ptch),
        .d_roll       (d_roll),
        .d_yaw        (d_yaw),
        .thrst        (thrst),
        .strt_cal     (strt_cal),
        .inertial_cal (inertial_cal),
        .cal_done     (cal_done),
        .motors_off   (motors_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (send_resp)   n_ack  = n_ack + 1;
        if (clr_cmd_rdy) n_clr  = n_clr + 1;
        if (strt_cal)    n_strt = n_strt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one command for exactly one cycle; DUT is expected in IDLE.
    task automatic issue(input logic [7:0] op, input logic [15:0] dat, input string tag);
        cmd_rdy = 1'b1;
        cmd     = op;
        data    = dat;
        @(negedge clk);
        chk(tag, 32'(clr_cmd_rdy), 32'd1);
        @(posedge clk); #1;
        cmd_rdy = 1'b0;
    endtask

    // Wait (bounded) for the ack request, then complete the transmission.
    task automatic serve_tx(input string tag);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (send_resp) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
        @(posedge clk); #1;
        resp_sent = 1'b1;
        @(posedge clk); #1;
        resp_sent = 1'b0;
    endtask

    // Bounded wait for strt_cal; returns SPIN cycles seen before it.
    task automatic wait_strt(output bit found, output int k);
        found = 1'b0;
        k = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (strt_cal) begin
                found = 1'b1;
            end else begin
                k = k + 1;
                // A stray cal_done during spin-up must be ignored.
                cal_done = (k == 100);
            end
        end
        cal_done = 1'b0;
    endtask

    initial begin
        int  a0;
        int  c0;
        int  s0;
        int  k;
        bit  found;

        n_vec = 0; n_err = 0; n_ack = 0; n_clr = 0; n_strt = 0;
        rst = 1'b1; cmd_rdy = 1'b1; cmd = 8'h02; data = 16'h1234;
        resp_sent = 1'b0; cal_done = 1'b0;

        // Reset state, with a pending command that must not be consumed.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_clr", 32'(clr_cmd_rdy), 32'd0);
        chk("rst_send", 32'(send_resp), 32'd0);
        chk("rst_strt", 32'(strt_cal), 32'd0);
        chk("rst_inert", 32'(inertial_cal), 32'd0);
        chk("rst_moff", 32'(motors_off), 32'd1);
        chk("rst_ptch", 32'(d_ptch), 32'd0);
        chk("rst_thrst", 32'(thrst), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; cmd_rdy = 1'b0;
        @(posedge clk); #1;

        // SET_PTCH -128
        a0 = n_ack; c0 = n_clr;
        issue(8'h02, 16'hFF80, "ptch_clr");
        chk("ptch_val", 32'(d_ptch), 32'h0000FF80);
        chk("ptch_send", 32'(send_resp), 32'd1);
        chk("ptch_resp", 32'(resp), 32'h000000A5);
        serve_tx("ptch_tx");
        chk("ptch_nclr", 32'(n_clr - c0), 32'd1);
        chk("ptch_nack", 32'(n_ack - a0), 32'd1);

        // SET_THRST drops upper data bits
        a0 = n_ack;
        issue(8'h05, 16'hFFFF, "thr_clr");
        chk("thr_val", 32'(thrst), 32'h1FF);
        serve_tx("thr_tx");
        chk("thr_nack", 32'(n_ack - a0), 32'd1);

        // CALIBRATE: spin-up then calibration handshake
        a0 = n_ack; s0 = n_strt;
        issue(8'h06, 16'h0000, "cal_clr");
        chk("cal_moff", 32'(motors_off), 32'd0);
        chk("cal_inert", 32'(inertial_cal), 32'd1);
        chk("cal_nosend", 32'(send_resp), 32'd0);
        wait_strt(found, k);
        chk("cal_strt_seen", 32'(found), 32'd1);
        chk("cal_spin_cyc", 32'(k), 32'd511);
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #1;
        chk("cal_wait_send", 32'(send_resp), 32'd0);
        chk("cal_wait_inert", 32'(inertial_cal), 32'd1);
        chk("cal_nstrt", 32'(n_strt - s0), 32'd1);
        cal_done = 1'b1;
        @(posedge clk); #1;
        cal_done = 1'b0;
        chk("cal_ack", 32'(send_resp), 32'd1);
        chk("cal_inert_off", 32'(inertial_cal), 32'd0);
        serve_tx("cal_tx");
        chk("cal_nack", 32'(n_ack - a0), 32'd1);

        // EMER_LAND after nonzero setpoints, then MTRS_OFF
        issue(8'h03, 16'h1234, "roll_clr");
        serve_tx("roll_tx");
        issue(8'h04, 16'h8001, "yaw_clr");
        serve_tx("yaw_tx");
        chk("yaw_val", 32'(d_yaw), 32'h00008001);
        a0 = n_ack;
        issue(8'h07, 16'hABCD, "emer_clr");
        chk("emer_ptch", 32'(d_ptch), 32'd0);
        chk("emer_roll", 32'(d_roll), 32'd0);
        chk("emer_yaw", 32'(d_yaw), 32'd0);
        chk("emer_thrst", 32'(thrst), 32'd0);
        serve_tx("emer_tx");
        issue(8'h08, 16'h0000, "moff_clr");
        chk("moff_val", 32'(motors_off), 32'd1);
        serve_tx("moff_tx");
        chk("emer_moff_nack", 32'(n_ack - a0), 32'd2);

        // Command held off during WAIT_TX; resp_sent in ACK not credited
        a0 = n_ack; c0 = n_clr;
        issue(8'h03, 16'h0007, "bb_clr");
        resp_sent = 1'b1;
        cmd_rdy = 1'b1; cmd = 8'h3C; data = 16'h5555;
        @(negedge clk);
        chk("bb_hold_ack", 32'(clr_cmd_rdy), 32'd0);
        @(posedge clk); #1;
        resp_sent = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bb_hold_wait", 32'(clr_cmd_rdy), 32'd0);
            @(posedge clk); #1;
        end
        resp_sent = 1'b1;
        @(negedge clk);
        chk("bb_hold_last", 32'(clr_cmd_rdy), 32'd0);
        @(posedge clk); #1;
        resp_sent = 1'b0;
        @(negedge clk);
        chk("bb_serviced", 32'(clr_cmd_rdy), 32'd1);
        @(posedge clk); #1;
        cmd_rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bb_roll", 32'(d_roll), 32'd7);
        chk("bb_nack", 32'(n_ack - a0), 32'd1);
        chk("bb_nclr", 32'(n_clr - c0), 32'd2);

        // Reset in the middle of calibration
        a0 = n_ack;
        issue(8'h06, 16'h0000, "rc_clr");
        wait_strt(found, k);
        chk("rc_strt_seen", 32'(found), 32'd1);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rc_moff", 32'(motors_off), 32'd1);
        chk("rc_inert", 32'(inertial_cal), 32'd0);
        chk("rc_send", 32'(send_resp), 32'd0);
        cal_done = 1'b1;
        @(posedge clk); #1;
        cal_done = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rc_nack", 32'(n_ack - a0), 32'd0);
        issue(8'h02, 16'h0001, "rc_post_clr");
        serve_tx("rc_post_tx");
        chk("rc_post_ptch", 32'(d_ptch), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
